// File: rtl/score_pkg.sv
// Shared types and helpers for the score sequencer.
// State encoding, default point values and line-count decode.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int unsigned PTS1_DEF = 1;
  localparam int unsigned PTS2_DEF = 3;
  localparam int unsigned PTS3_DEF = 5;
  localparam int unsigned PTS4_DEF = 8;

  // Returns {valid, points}; counts outside 1..4 are not scoring events.
  function automatic logic [4:0] decode_pts(
    input logic [2:0] cnt,
    input logic [3:0] p1,
    input logic [3:0] p2,
    input logic [3:0] p3,
    input logic [3:0] p4
  );
    logic [4:0] r;
    r = 5'd0;
    unique case (1'b1)
      (cnt == 3'd1): r = {1'b1, p1};
      (cnt == 3'd2): r = {1'b1, p2};
      (cnt == 3'd3): r = {1'b1, p3};
      (cnt == 3'd4): r = {1'b1, p4};
      default:       r = 5'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/score_fifo.sv
// Small synchronous FIFO holding pending 4-bit point awards.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module score_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [3:0] din,
  output logic [3:0] head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [3:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          wr;
  logic          rd;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign head  = mem[rp];

  // Storage array, written on every accepted push.
  always_ff @(posedge clk) begin
    if (wr && !flush) mem[wp] <= din;
  end

  // Pointers and occupancy; flush empties the FIFO like a reset.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      unique case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/score_sequencer.sv
// Paces line-clear point awards out as single-cycle increment pulses.
// Latches game over and discards pending points once the game is lost.
module score_sequencer
  import score_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTS1  = PTS1_DEF,
  parameter int unsigned PTS2  = PTS2_DEF,
  parameter int unsigned PTS3  = PTS3_DEF,
  parameter int unsigned PTS4  = PTS4_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       clear_valid,
  input  logic [2:0] clear_count,
  input  logic       game_over,
  output logic       aligne,
  output logic       perdu,
  output logic       busy,
  output logic       dropped
);

  state_t     state;
  state_t     state_n;
  logic [3:0] rem;
  logic [3:0] rem_n;
  logic [4:0] dec;
  logic       ev;
  logic       push;
  logic       pop;
  logic       flush;
  logic       aligne_n;
  logic       dropped_n;
  logic [3:0] head;
  logic       full;
  logic       empty;

  assign dec = decode_pts(clear_count, 4'(PTS1), 4'(PTS2),
                          4'(PTS3), 4'(PTS4));
  assign ev  = clear_valid && dec[4];

  score_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  (dec[3:0]),
    .head (head),
    .full (full),
    .empty(empty)
  );

  // Next state, award countdown and FIFO control; game over wins.
  always_comb begin
    state_n   = state;
    rem_n     = rem;
    pop       = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    aligne_n  = 1'b0;
    dropped_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          rem_n   = head;
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (rem == 4'd0) begin
          state_n = IDLE;
        end else if (tick) begin
          aligne_n = 1'b1;
          rem_n    = rem - 4'd1;
          if (rem == 4'd1) state_n = IDLE;
        end
      end
      OVER: begin
        state_n = OVER;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (state != OVER) begin
      push      = ev;
      dropped_n = ev && full && !pop;
    end
    if (game_over) begin
      state_n   = OVER;
      rem_n     = 4'd0;
      flush     = 1'b1;
      pop       = 1'b0;
      push      = 1'b0;
      aligne_n  = 1'b0;
      dropped_n = 1'b0;
    end
  end

  // State, countdown and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rem     <= 4'd0;
      aligne  <= 1'b0;
      perdu   <= 1'b0;
      busy    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      aligne  <= aligne_n;
      perdu   <= (state_n == OVER);
      busy    <= !empty || (state == EMIT);
      dropped <= dropped_n;
    end
  end

endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer: vector table, directed corners
// and random traffic against a queue-based award model.
module tb_score_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       clear_valid = 1'b0;
  logic [2:0] clear_count = 3'd0;
  logic       game_over = 1'b0;
  logic       aligne;
  logic       perdu;
  logic       busy;
  logic       dropped;

  score_sequencer #(
    .DEPTH(DEPTH), .PTS1(1), .PTS2(3), .PTS3(5), .PTS4(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .clear_valid(clear_valid),
    .clear_count(clear_count),
    .game_over  (game_over),
    .aligne     (aligne),
    .perdu      (perdu),
    .busy       (busy),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int al_cnt = 0;
  int dr_cnt = 0;

  // Reference model: queue of waiting awards plus the award in progress.
  int  mq[$];
  bit  m_active = 0;
  int  m_left = 0;
  bit  m_over = 0;
  bit  e_al = 0, e_dr = 0, e_pd = 0, e_busy = 0;

  typedef struct {
    logic [2:0] cc;
    int         pulses;
  } vec_t;
  vec_t vt[8];

  function automatic int pts(input logic [2:0] cc);
    case (cc)
      3'd1: return 1;
      3'd2: return 3;
      3'd3: return 5;
      3'd4: return 8;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic t, input logic cv, input logic [2:0] cc,
                     input logic go, input logic rst);
    int  p;
    bit  takes;
    tick        = t;
    clear_valid = cv;
    clear_count = cc;
    game_over   = go;
    reset       = rst;
    if (rst) begin
      mq.delete();
      m_active = 0; m_left = 0; m_over = 0;
      e_al = 0; e_dr = 0; e_pd = 0; e_busy = 0;
    end else if (m_over) begin
      e_al = 0; e_dr = 0; e_pd = 1; e_busy = 0;
    end else begin
      e_busy = (mq.size() != 0) || m_active;
      if (go) begin
        e_al = 0; e_dr = 0; e_pd = 1;
        m_over = 1; mq.delete(); m_active = 0; m_left = 0;
      end else begin
        e_pd = 0; e_dr = 0;
        e_al = m_active && t;
        takes = !m_active && (mq.size() != 0);
        if (m_active && t) begin
          m_left--;
          if (m_left == 0) m_active = 0;
        end
        if (takes) begin
          m_left = mq.pop_front();
          m_active = 1;
        end
        p = pts(cc);
        if (cv && p != 0) begin
          if (mq.size() < DEPTH) mq.push_back(p);
          else e_dr = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    check("aligne", int'(aligne), int'(e_al));
    check("dropped", int'(dropped), int'(e_dr));
    check("perdu", int'(perdu), int'(e_pd));
    check("busy", int'(busy), int'(e_busy));
    if (aligne) al_cnt++;
    if (dropped) dr_cnt++;
  endtask

  task automatic idle_n(input int n, input int period);
    for (int i = 0; i < n; i++)
      cyc((period > 0) && ((i % period) == period - 1), 0, 3'd0, 0, 0);
  endtask

  initial begin
    vt[0] = '{3'd0, 0};
    vt[1] = '{3'd1, 1};
    vt[2] = '{3'd2, 3};
    vt[3] = '{3'd3, 5};
    vt[4] = '{3'd4, 8};
    vt[5] = '{3'd5, 0};
    vt[6] = '{3'd6, 0};
    vt[7] = '{3'd7, 0};

    cyc(0, 0, 3'd0, 0, 1);
    cyc(0, 0, 3'd0, 0, 1);
    check("rst_aligne", int'(aligne), 0);
    check("rst_perdu", int'(perdu), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_dropped", int'(dropped), 0);

    // Each line count awards its point value, one pulse per tick.
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 3'd0, 0, 1);
      al_cnt = 0; dr_cnt = 0;
      cyc(0, 1, vt[k].cc, 0, 0);
      idle_n(60, 5);
      check($sformatf("tbl_pulses_cc%0d", vt[k].cc), al_cnt, vt[k].pulses);
      check("tbl_dropped", dr_cnt, 0);
      check("tbl_busy_end", int'(busy), 0);
    end

    // Fill the FIFO behind an active award, then overflow once.
    cyc(0, 0, 3'd0, 0, 1);
    al_cnt = 0; dr_cnt = 0;
    for (int i = 0; i < 5; i++) cyc(0, 1, 3'd4, 0, 0);
    check("fill_no_drop", dr_cnt, 0);
    cyc(0, 1, 3'd4, 0, 0);
    check("fill_drop", dr_cnt, 1);
    idle_n(200, 1);
    check("fill_total", al_cnt, 40);
    check("fill_busy_end", int'(busy), 0);

    // Game over with 3 points left and a tick in the same cycle.
    cyc(0, 0, 3'd0, 0, 1);
    cyc(0, 1, 3'd3, 0, 0);
    cyc(0, 1, 3'd2, 0, 0);
    cyc(1, 0, 3'd0, 0, 0);
    cyc(1, 0, 3'd0, 0, 0);
    al_cnt = 0;
    cyc(1, 0, 3'd0, 1, 0);
    check("go_no_aligne", int'(aligne), 0);
    check("go_perdu", int'(perdu), 1);
    for (int i = 0; i < 20; i++) cyc(1, 1, 3'd4, 0, 0);
    check("go_after_pulses", al_cnt, 0);
    check("go_perdu_held", int'(perdu), 1);
    check("go_busy", int'(busy), 0);

    // Reset mid-award, then a fresh single-point award.
    cyc(0, 0, 3'd0, 0, 1);
    cyc(0, 1, 3'd4, 0, 0);
    cyc(0, 0, 3'd0, 0, 0);
    cyc(1, 0, 3'd0, 0, 0);
    cyc(1, 0, 3'd0, 0, 0);
    cyc(0, 0, 3'd0, 0, 1);
    check("rst_emit_aligne", int'(aligne), 0);
    check("rst_emit_busy", int'(busy), 0);
    check("rst_emit_perdu", int'(perdu), 0);
    al_cnt = 0;
    cyc(0, 1, 3'd1, 0, 0);
    idle_n(30, 3);
    check("rst_then_one", al_cnt, 1);

    // A tick coinciding with the event in IDLE is not counted.
    cyc(0, 0, 3'd0, 0, 1);
    al_cnt = 0;
    cyc(1, 1, 3'd2, 0, 0);
    cyc(1, 0, 3'd0, 0, 0);
    check("tick_ev_uncounted", al_cnt, 0);
    idle_n(30, 3);
    check("tick_ev_total", al_cnt, 3);

    // Random traffic against the model.
    cyc(0, 0, 3'd0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
          3'($urandom_range(0, 7)), (r >= 3) && (r < 5), r < 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/score_sequencer.md
# score_sequencer

Controller that sits in front of the BCD score counter and its 7‑segment display driver. It accepts line‑clear events from the game logic, converts each to a point value, buffers pending awards in a small FIFO, and paces them out as single‑cycle `aligne` increment pulses (one per `tick`), so the displayed score visibly counts up. It also latches game over, drives the counter's `perdu` input, and discards all pending points once the game is lost.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries, power of two, at least 2.
- `PTS1`, 1: points for 1 line.
- `PTS2`, 3: points for 2 lines.
- `PTS3`, 5: points for 3 lines.
- `PTS4`, 8: points for 4 lines. All `PTSn` are in 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active‑high.
- `tick` in 1: pacing strobe, one‑cycle pulse (e.g. ~10 Hz enable).
- `clear_valid` in 1: one‑cycle event strobe from game logic.
- `clear_count` in 3: lines cleared, sampled when `clear_valid`=1.
- `game_over` in 1: level from game logic.
- `aligne` out 1: registered one‑cycle increment pulse to the score counter.
- `perdu` out 1: registered game‑over flag to the score counter.
- `busy` out 1: high while the FIFO is non‑empty or the state is not IDLE/OVER.
- `dropped` out 1: registered one‑cycle pulse when an event is lost because the FIFO is full.

## Operation
- Decode: `clear_count` 1..4 maps to `PTS1`..`PTS4`. Values 0 and 5..7 are ignored: no push and no `dropped`.
- Push: a valid event with the FIFO not full writes its 4‑bit point value. FIFO full with no pop in the same cycle: event discarded, `dropped`=1 next cycle. Push and pop in the same cycle are allowed when full, and the push succeeds.
- FSM states: IDLE, EMIT, OVER.
  - IDLE: FIFO non‑empty: pop head into the 4‑bit `remaining` register, go to EMIT.
  - EMIT: on `tick`, `aligne`=1 next cycle and `remaining` decrements. When `remaining` reaches 0 (after the last tick's decrement), return to IDLE.
  - Any state: `game_over`=1 goes to OVER, flushes the FIFO, clears `remaining`, and sets `perdu`. Game over has priority over push, pop and tick in the same cycle.
  - OVER: absorbing until `reset`. Events are ignored, `aligne`=0, `dropped`=0.
- Reset values: `aligne`=0, `perdu`=0, `busy`=0, `dropped`=0, FIFO empty, `remaining`=0, state IDLE. Reset mid‑EMIT discards all pending points.

## Timing
- `clear_valid` at cycle t: entry present at t+1. IDLE pops at t+1; state is EMIT with `remaining` loaded at t+2.
- `tick` sampled in EMIT at cycle c gives `aligne` high for exactly cycle c+1. There is at most one `aligne` per `tick`.
- A `tick` in IDLE or during the pop cycle is not counted; no points are lost.
- N points need N ticks. Back‑to‑back FIFO entries add one IDLE cycle between awards.
- `game_over` at cycle t: `perdu`=1 from t+1. No `aligne` from t+1 on, even if a tick occurred at t.
- `busy` is registered and reflects the state and FIFO occupancy of the previous edge.

## Structure
- Package `score_pkg`: state enum (IDLE, EMIT, OVER), default point constants, and the `clear_count` to points decode function.
- Sub‑module `score_fifo`: synchronous FIFO, width 4, depth `DEPTH`, with `push`, `pop`, `flush`, `full`, `empty` and head data. Simultaneous push and pop are legal when full.
- The top level contains the FSM, the `remaining` counter and the output registers.

## Test plan
- Reset, then `clear_count`=2 with ticks every 5 cycles → exactly 3 `aligne` pulses, each one cycle wide and one cycle after a tick; then `busy` falls.
- `clear_count`=0, then =6 → no push, no `aligne`, `dropped` stays 0.
- Five `clear_count`=4 events in consecutive cycles with no ticks, `DEPTH`=4 → first one popped to EMIT; second through fifth fill the FIFO; no `dropped` pulse. A sixth event → `dropped` pulse. Then supplying ticks → 40 `aligne` pulses total.
- `game_over` asserted mid‑EMIT with 3 points remaining and a tick in the same cycle → no further `aligne`, `perdu`=1 from the next cycle, FIFO empty, later events ignored.
- `reset` during EMIT → all outputs 0 the next cycle. A following `clear_count`=1 → exactly 1 `aligne`.
- Tick and `clear_valid` in the same cycle from IDLE → that tick is not counted; award completes on later ticks.
